// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad one column at a time,
// debounces press and release, and buffers one key code for a CPU reader.
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   keyboard_row  row sense lines, active-low, externally pulled up
//   keyboard_col  column drive, active-low, one-cold
//   key_code      {row, col} code of the last accepted key
//   key_valid     high while an unread key is buffered
//   key_ack       single-cycle read strobe, clears key_valid
//   key_held      high while the accepted key is still physically pressed
//   key_overflow  sticky: a key was accepted while key_valid was already high
module keypad_scanner #(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned DEBOUNCE_CNT = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] keyboard_row,
  output logic [3:0] keyboard_col,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_held,
  output logic       key_overflow
);

  localparam int unsigned DWELL_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DEB_W   = (DEBOUNCE_CNT > 2) ? $clog2(DEBOUNCE_CNT) : 1;

  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {
    SCAN        = 2'd0,
    DEB_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    DEB_RELEASE = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [1:0]         col_q, col_d;
  logic [1:0]         row_q, row_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DEB_W-1:0]   deb_cnt_q, deb_cnt_d;
  logic [3:0]         key_code_d;
  logic               key_valid_d, key_held_d, key_overflow_d;

  logic       row_any_c;
  logic [1:0] row_idx_c;
  logic       row_match_c;

  // Lowest-numbered low row wins when several rows are low.
  always_comb begin
    row_any_c = (keyboard_row != 4'hF);
    if (!keyboard_row[0])      row_idx_c = 2'd0;
    else if (!keyboard_row[1]) row_idx_c = 2'd1;
    else if (!keyboard_row[2]) row_idx_c = 2'd2;
    else                       row_idx_c = 2'd3;
    row_match_c = row_any_c && (row_idx_c == row_q);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= SCAN;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SCAN: begin
        if (dwell_q == DWELL_LAST && row_any_c) state_d = DEB_PRESS;
      end
      DEB_PRESS: begin
        if (!row_match_c)               state_d = SCAN;
        else if (deb_cnt_q == DEB_LAST) state_d = PRESSED;
      end
      PRESSED: begin
        if (!row_any_c) state_d = DEB_RELEASE;
      end
      DEB_RELEASE: begin
        if (!row_any_c && deb_cnt_q == DEB_LAST) state_d = SCAN;
      end
      default: state_d = SCAN;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    col_d          = col_q;
    row_d          = row_q;
    dwell_d        = dwell_q;
    deb_cnt_d      = deb_cnt_q;
    key_code_d     = key_code;
    key_valid_d    = key_valid;
    key_held_d     = key_held;
    key_overflow_d = key_overflow;

    // A read clears the buffer; an acceptance in the same cycle overrides below.
    if (key_ack && key_valid) key_valid_d = 1'b0;

    unique case (state_q)
      SCAN: begin
        deb_cnt_d = '0;
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (row_any_c) row_d = row_idx_c;
          else           col_d = col_q + 2'd1;
        end else begin
          dwell_d = dwell_q + DWELL_W'(1);
        end
      end
      DEB_PRESS: begin
        if (!row_match_c) begin
          col_d     = col_q + 2'd1;
          dwell_d   = '0;
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
          deb_cnt_d   = '0;
          key_code_d  = {row_q, col_q};
          key_valid_d = 1'b1;
          key_held_d  = 1'b1;
          if (key_valid && !key_ack) key_overflow_d = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end
      PRESSED: begin
        deb_cnt_d = '0;
      end
      DEB_RELEASE: begin
        if (row_any_c) begin
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
          deb_cnt_d  = '0;
          col_d      = col_q + 2'd1;
          dwell_d    = '0;
          key_held_d = 1'b0;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end
      default: begin
        deb_cnt_d = '0;
        dwell_d   = '0;
      end
    endcase
  end

  // Datapath and output registers; column drive follows the next column index.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= 2'd0;
      row_q        <= 2'd0;
      dwell_q      <= '0;
      deb_cnt_q    <= '0;
      keyboard_col <= 4'b1110;
      key_code     <= 4'h0;
      key_valid    <= 1'b0;
      key_held     <= 1'b0;
      key_overflow <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      dwell_q      <= dwell_d;
      deb_cnt_q    <= deb_cnt_d;
      keyboard_col <= 4'(~(4'b0001 << col_d));
      key_code     <= key_code_d;
      key_valid    <= key_valid_d;
      key_held     <= key_held_d;
      key_overflow <= key_overflow_d;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed testbench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CNT=8.
// A keypad model pulls row press_r low whenever column press_c is driven.
module tb_keypad_scanner;

  localparam int unsigned SCAN_DIV     = 4;
  localparam int unsigned DEBOUNCE_CNT = 8;

  logic       clk;
  logic       rst;
  logic [3:0] keyboard_row;
  logic [3:0] keyboard_col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack;
  logic       key_held;
  logic       key_overflow;

  logic       press_en;
  logic [1:0] press_r;
  logic [1:0] press_c;

  int errors = 0;
  int checks = 0;

  keypad_scanner #(
    .SCAN_DIV    (SCAN_DIV),
    .DEBOUNCE_CNT(DEBOUNCE_CNT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .keyboard_row(keyboard_row),
    .keyboard_col(keyboard_col),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_ack     (key_ack),
    .key_held    (key_held),
    .key_overflow(key_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical keypad: a pressed switch connects its row to its column.
  always_comb begin
    keyboard_row = 4'hF;
    if (press_en && !keyboard_col[press_c]) keyboard_row[press_r] = 1'b0;
  end

  function automatic logic [3:0] col_pat(input int c);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << c);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns on the first cycle column c is driven (dwell 0).
  task automatic wait_col_start(input int c);
    int n;
    logic [3:0] tgt;
    tgt = col_pat(c);
    n = 0;
    while (keyboard_col == tgt && n < 64) begin step(1); n++; end
    while (keyboard_col != tgt && n < 64) begin step(1); n++; end
    check("wait_col", 32'(keyboard_col), 32'(tgt));
  endtask

  task automatic press_key(input int r, input int c);
    press_r  = 2'(r);
    press_c  = 2'(c);
    wait_col_start(c);
    press_en = 1'b1;
  endtask

  task automatic release_key();
    press_en = 1'b0;
    step(10);
  endtask

  initial begin
    int stray;
    rst      = 1'b1;
    key_ack  = 1'b0;
    press_en = 1'b0;
    press_r  = 2'd0;
    press_c  = 2'd0;
    step(3);

    // Reset values
    check("rst_col",   32'(keyboard_col), 32'hE);
    check("rst_code",  32'(key_code),     32'h0);
    check("rst_valid", 32'(key_valid),    32'h0);
    check("rst_held",  32'(key_held),     32'h0);
    check("rst_ovf",   32'(key_overflow), 32'h0);

    // Idle scan: each column for 4 cycles, wrapping back to column 0
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step(1);
      check("idle_col",   32'(keyboard_col), 32'(col_pat((k / 4) % 4)));
      check("idle_valid", 32'(key_valid),    32'h0);
    end

    // Ack with nothing buffered is ignored
    key_ack = 1'b1;
    step(1);
    key_ack = 1'b0;
    step(1);
    check("ack_idle_valid", 32'(key_valid), 32'h0);

    // Press row 2 / col 1 -> code 9, latency sample+DEBOUNCE_CNT+1
    press_key(2, 1);
    step(8);
    check("deb_col_frozen", 32'(keyboard_col), 32'(col_pat(1)));
    step(3);
    check("press_latency_lo", 32'(key_valid), 32'h0);
    step(1);
    check("press_valid", 32'(key_valid), 32'h1);
    check("press_code",  32'(key_code),  32'h9);
    check("press_held",  32'(key_held),  32'h1);
    key_ack = 1'b1;
    step(1);
    key_ack = 1'b0;
    check("ack_clear_valid", 32'(key_valid),    32'h0);
    check("ack_held",        32'(key_held),     32'h1);
    check("ack_no_ovf",      32'(key_overflow), 32'h0);

    // Keep holding: no second assertion, column stays frozen
    stray = 0;
    repeat (40) begin
      step(1);
      if (key_valid !== 1'b0 || keyboard_col !== col_pat(1)) stray++;
    end
    check("hold_single_valid", 32'(stray), 32'h0);

    // Release: 1 cycle to leave PRESSED plus 8 stable high cycles
    press_en = 1'b0;
    step(8);
    check("release_held_still", 32'(key_held),     32'h1);
    check("release_col_still",  32'(keyboard_col), 32'(col_pat(1)));
    step(1);
    check("release_held_off", 32'(key_held),     32'h0);
    check("release_next_col", 32'(keyboard_col), 32'(col_pat(2)));

    // Bounce on row 1 / col 2: drop out to the next column, then accept
    press_key(1, 2);
    step(6);
    press_en = 1'b0;
    step(1);
    check("bounce_col_next", 32'(keyboard_col), 32'(col_pat(3)));
    check("bounce_no_valid", 32'(key_valid),    32'h0);
    press_en = 1'b1;
    wait_col_start(2);
    step(11);
    check("bounce_latency_lo", 32'(key_valid), 32'h0);
    step(1);
    check("bounce_valid", 32'(key_valid), 32'h1);
    check("bounce_code",  32'(key_code),  32'h6);
    key_ack = 1'b1;
    step(1);
    key_ack = 1'b0;
    release_key();
    check("bounce_released", 32'(key_held), 32'h0);

    // Overflow: key 0 then key 5 without ack
    press_key(0, 0);
    step(12);
    check("ovf1_code0", 32'(key_code),  32'h0);
    check("ovf1_valid", 32'(key_valid), 32'h1);
    release_key();
    press_key(1, 1);
    step(12);
    check("ovf1_code5", 32'(key_code),     32'h5);
    check("ovf1_valid2", 32'(key_valid),   32'h1);
    check("ovf1_flag",  32'(key_overflow), 32'h1);
    key_ack = 1'b1;
    step(1);
    key_ack = 1'b0;
    check("ovf1_ack_valid", 32'(key_valid),    32'h0);
    check("ovf1_sticky",    32'(key_overflow), 32'h1);
    release_key();

    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("ovf_rst_clear", 32'(key_overflow), 32'h0);

    // Same sequence but ack coincides with the second acceptance
    press_key(0, 0);
    step(12);
    check("ovf2_valid0", 32'(key_valid), 32'h1);
    release_key();
    press_key(1, 1);
    step(11);
    key_ack = 1'b1;
    step(1);
    key_ack = 1'b0;
    check("ovf2_valid", 32'(key_valid),    32'h1);
    check("ovf2_code",  32'(key_code),     32'h5);
    check("ovf2_noovf", 32'(key_overflow), 32'h0);

    // Reset mid-debounce with a key still buffered
    release_key();
    press_key(0, 0);
    step(6);
    check("pre_rst_valid", 32'(key_valid), 32'h1);
    rst = 1'b1;
    step(1);
    check("mid_rst_col",   32'(keyboard_col), 32'hE);
    check("mid_rst_code",  32'(key_code),     32'h0);
    check("mid_rst_valid", 32'(key_valid),    32'h0);
    check("mid_rst_held",  32'(key_held),     32'h0);
    check("mid_rst_ovf",   32'(key_overflow), 32'h0);
    rst      = 1'b0;
    press_en = 1'b0;
    step(3);
    check("post_rst_col0", 32'(keyboard_col), 32'(col_pat(0)));
    step(1);
    check("post_rst_col1", 32'(keyboard_col), 32'(col_pat(1)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
